// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the 5-stage MIPS core.
//
// This stage captures decoded fields and register-file operands into the
// EX-stage bundle. While capturing, it forwards operands from EX and MEM.
// It also detects load-use hazards and inserts bubbles for them. WB->ID
// bypassing is handled inside the register file, so it is not repeated here.
//
// Ports
//   clk, rst_n                       clock / async active-low reset
//   id_valid, id_pc                  ID instruction present, its PC
//   id_rs, id_rt, id_rd              source / destination register indices
//   id_rdata1, id_rdata2             register file read data (rs / rt)
//   id_imm                           sign-extended immediate
//   id_ctrl                          [0] reg_write [1] mem_read [2] mem_write
//                                    [3] mem_to_reg [4] alu_src [5] reg_dst
//                                    [9:6] alu_op
//   ex_fwd_we/_reg/_data             ALU result of the instruction in EX
//   mem_fwd_we/_reg/_data            final result of the instruction in MEM
//   flush                            kill the ID instruction (taken branch)
//   ex_hold                          downstream stall, freeze this register
//   id_ready                         ID may advance (combinational)
//   ex_valid, ex_pc, ex_a, ex_b,
//   ex_imm, ex_rs, ex_rt, ex_wreg,
//   ex_ctrl                          registered EX-stage bundle
//   bubble_cnt                       saturating count of load-use bubbles
//
// BUBBLE_SAT is the ceiling at which bubble_cnt stops counting. Its default
// is full scale.
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int          DW         = 32,
  parameter int          RW         = 5,
  parameter logic [15:0] BUBBLE_SAT = 16'hFFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [DW-1:0] id_pc,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rdata1,
  input  logic [DW-1:0] id_rdata2,
  input  logic [DW-1:0] id_imm,
  input  logic [9:0]    id_ctrl,
  input  logic          ex_fwd_we,
  input  logic [RW-1:0] ex_fwd_reg,
  input  logic [DW-1:0] ex_fwd_data,
  input  logic          mem_fwd_we,
  input  logic [RW-1:0] mem_fwd_reg,
  input  logic [DW-1:0] mem_fwd_data,
  input  logic          flush,
  input  logic          ex_hold,
  output logic          id_ready,
  output logic          ex_valid,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_imm,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_wreg,
  output logic [9:0]    ex_ctrl,
  output logic [15:0]   bubble_cnt
);

  logic [RW-1:0] wreg;
  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;
  logic          luh;
  logic          bubble;

  assign wreg = id_ctrl[5] ? id_rd : id_rt;

  // EX is the younger producer, so it beats MEM. Register 0 is never forwarded.
  always_comb begin
    fwd_a = id_rdata1;
    if (id_rs != '0) begin
      if (ex_fwd_we && ex_fwd_reg == id_rs)        fwd_a = ex_fwd_data;
      else if (mem_fwd_we && mem_fwd_reg == id_rs) fwd_a = mem_fwd_data;
    end
  end

  always_comb begin
    fwd_b = id_rdata2;
    if (id_rt != '0) begin
      if (ex_fwd_we && ex_fwd_reg == id_rt)        fwd_b = ex_fwd_data;
      else if (mem_fwd_we && mem_fwd_reg == id_rt) fwd_b = mem_fwd_data;
    end
  end

  // rt is compared even for instructions that do not read it. This is
  // conservative, but it never misses a real dependency.
  assign luh = id_valid && ex_valid && ex_ctrl[1] && (ex_wreg != '0) &&
               ((ex_wreg == id_rs) || (ex_wreg == id_rt));

  // A flush kills the stalled instruction anyway, so ID may move on.
  assign id_ready = !ex_hold && !(luh && !flush);

  assign bubble = flush || luh || !id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_wreg    <= '0;
      ex_ctrl    <= '0;
      bubble_cnt <= '0;
    end else if (!ex_hold) begin
      if (bubble) begin
        ex_valid <= 1'b0;
        ex_pc    <= '0;
        ex_a     <= '0;
        ex_b     <= '0;
        ex_imm   <= '0;
        ex_rs    <= '0;
        ex_rt    <= '0;
        ex_wreg  <= '0;
        ex_ctrl  <= '0;
        if (luh && !flush && bubble_cnt != BUBBLE_SAT)
          bubble_cnt <= bubble_cnt + 16'd1;
      end else begin
        ex_valid <= 1'b1;
        ex_pc    <= id_pc;
        ex_a     <= fwd_a;
        ex_b     <= fwd_b;
        ex_imm   <= id_imm;
        ex_rs    <= id_rs;
        ex_rt    <= id_rt;
        ex_wreg  <= wreg;
        ex_ctrl  <= id_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage. A reference model of the EX-stage
// bundle is kept here and compared every cycle. Directed scenarios run
// first, then randomized traffic, then bubble-counter saturation.
// The counter ceiling is lowered so that saturation can be reached quickly.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam logic [15:0] SAT = 16'd40;

  typedef struct packed {
    logic        v;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rs, rt, wreg;
    logic [9:0]  ctrl;
  } ex_t;

  logic        clk, rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rdata1, id_rdata2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [9:0]  id_ctrl;
  logic        ex_fwd_we, mem_fwd_we;
  logic [4:0]  ex_fwd_reg, mem_fwd_reg;
  logic [31:0] ex_fwd_data, mem_fwd_data;
  logic        flush, ex_hold;
  logic        id_ready, ex_valid;
  logic [31:0] ex_pc, ex_a, ex_b, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_wreg;
  logic [9:0]  ex_ctrl;
  logic [15:0] bubble_cnt;

  ex_t         m;
  logic [15:0] m_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  id_ex_stage #(.DW(32), .RW(5), .BUBBLE_SAT(SAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .ex_fwd_we(ex_fwd_we), .ex_fwd_reg(ex_fwd_reg),
    .ex_fwd_data(ex_fwd_data), .mem_fwd_we(mem_fwd_we),
    .mem_fwd_reg(mem_fwd_reg), .mem_fwd_data(mem_fwd_data),
    .flush(flush), .ex_hold(ex_hold), .id_ready(id_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
    .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Operand value as seen by EX: the youngest in-flight producer of a
  // non-zero register wins, otherwise the register file value.
  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return rf;
    if (ex_fwd_we && ex_fwd_reg == idx) return ex_fwd_data;
    if (mem_fwd_we && mem_fwd_reg == idx) return mem_fwd_data;
    return rf;
  endfunction

  task automatic model_clear();
    m     = '0;
    m_cnt = '0;
  endtask

  task automatic check_outputs();
    chk("ex_valid", ex_valid, m.v);
    chk("ex_pc", ex_pc, m.pc);
    chk("ex_a", ex_a, m.a);
    chk("ex_b", ex_b, m.b);
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_rs", ex_rs, m.rs);
    chk("ex_rt", ex_rt, m.rt);
    chk("ex_wreg", ex_wreg, m.wreg);
    chk("ex_ctrl", ex_ctrl, m.ctrl);
    chk("bubble_cnt", bubble_cnt, m_cnt);
  endtask

  // Called at a falling edge, with inputs already driven. It checks
  // id_ready, advances the model across one rising edge, and then checks
  // the bundle at the next falling edge.
  task automatic cycle();
    logic hazard, rdy;
    ex_t  nxt;
    hazard = id_valid && m.v && m.ctrl[1] && m.wreg != 0 &&
             (m.wreg == id_rs || m.wreg == id_rt);
    rdy = !ex_hold && !(hazard && !flush);
    #1 chk("id_ready", id_ready, rdy);
    @(posedge clk);
    if (!ex_hold) begin
      if (flush || hazard || !id_valid) begin
        if (hazard && !flush && m_cnt < SAT) m_cnt = m_cnt + 1;
        m = '0;
      end else begin
        nxt.v    = 1'b1;
        nxt.pc   = id_pc;
        nxt.a    = operand(id_rs, id_rdata1);
        nxt.b    = operand(id_rt, id_rdata2);
        nxt.imm  = id_imm;
        nxt.rs   = id_rs;
        nxt.rt   = id_rt;
        nxt.wreg = id_ctrl[5] ? id_rd : id_rt;
        nxt.ctrl = id_ctrl;
        m = nxt;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_pc = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rdata1 = 0; id_rdata2 = 0; id_imm = 0; id_ctrl = 0;
    ex_fwd_we = 0; ex_fwd_reg = 0; ex_fwd_data = 0;
    mem_fwd_we = 0; mem_fwd_reg = 0; mem_fwd_data = 0;
    flush = 0; ex_hold = 0;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [9:0] ctrl);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rdata1 = r1; id_rdata2 = r2; id_ctrl = ctrl;
    id_pc = id_pc + 4; id_imm = $urandom;
  endtask

  // Register indices are drawn from a small range so that forwarding and
  // hazards occur often.
  task automatic rand_inputs();
    id_valid     = ($urandom_range(0, 9) != 0);
    id_pc        = $urandom;
    id_rs        = 5'($urandom_range(0, 3));
    id_rt        = 5'($urandom_range(0, 3));
    id_rd        = 5'($urandom_range(0, 3));
    id_rdata1    = $urandom;
    id_rdata2    = $urandom;
    id_imm       = $urandom;
    id_ctrl      = 10'($urandom);
    ex_fwd_we    = $urandom_range(0, 1) == 1;
    ex_fwd_reg   = 5'($urandom_range(0, 3));
    ex_fwd_data  = $urandom;
    mem_fwd_we   = $urandom_range(0, 1) == 1;
    mem_fwd_reg  = 5'($urandom_range(0, 3));
    mem_fwd_data = $urandom;
    flush        = ($urandom_range(0, 9) == 0);
    ex_hold      = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    model_clear();
    #12;
    check_outputs();
    chk("rst_id_ready", id_ready, 1'b1);
    @(negedge clk);
    rst_n = 1;

    // Pass-through: reg_dst=1, reg_write=1
    set_id(5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 10'h021);
    cycle();
    chk("pt_a", ex_a, 32'h11);
    chk("pt_b", ex_b, 32'h22);
    chk("pt_wreg", ex_wreg, 5'd5);
    chk("pt_valid", ex_valid, 1'b1);

    // Forward priority
    set_id(5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 10'h021);
    ex_fwd_we = 1; ex_fwd_reg = 3; ex_fwd_data = 32'hAAAA;
    mem_fwd_we = 1; mem_fwd_reg = 3; mem_fwd_data = 32'hBBBB;
    cycle();
    chk("fwd_ex", ex_a, 32'hAAAA);
    ex_fwd_we = 0;
    cycle();
    chk("fwd_mem", ex_a, 32'hBBBB);
    set_id(5'd0, 5'd4, 5'd5, 32'h77, 32'h22, 10'h021);
    ex_fwd_we = 1; ex_fwd_reg = 0; mem_fwd_reg = 0;
    cycle();
    chk("fwd_r0", ex_a, 32'h77);

    // Asynchronous reset in the middle of a cycle, while ex_valid=1
    #2 rst_n = 0;
    #1;
    chk("mrst_valid", ex_valid, 1'b0);
    chk("mrst_a", ex_a, 32'h0);
    chk("mrst_ctrl", ex_ctrl, 10'h0);
    chk("mrst_cnt", bubble_cnt, 16'h0);
    chk("mrst_ready", id_ready, 1'b1);
    model_clear();
    @(negedge clk);
    rst_n = 1;
    idle_inputs();

    // Load-use: lw $8 (rt=8, mem_read, reg_write, mem_to_reg), then a user of $8
    set_id(5'd1, 5'd8, 5'd0, 32'h5, 32'h6, 10'h00B);
    cycle();
    set_id(5'd8, 5'd9, 5'd10, 32'hDEAD, 32'h9, 10'h021);
    #1 chk("lu_ready", id_ready, 1'b0);
    #1;
    cycle();
    chk("lu_bubble", ex_valid, 1'b0);
    chk("lu_cnt", bubble_cnt, 16'd1);
    mem_fwd_we = 1; mem_fwd_reg = 8; mem_fwd_data = 32'h1234;
    cycle();
    chk("lu_capture_a", ex_a, 32'h1234);
    chk("lu_capture_v", ex_valid, 1'b1);
    mem_fwd_we = 0;

    // Hold beats flush
    ex_hold = 1; flush = 1;
    repeat (3) begin
      cycle();
      chk("hold_ready", id_ready, 1'b0);
      chk("hold_valid", ex_valid, 1'b1);
    end
    ex_hold = 0;
    cycle();
    chk("flush_valid", ex_valid, 1'b0);
    flush = 0;

    // Randomized traffic
    repeat (3000) begin
      rand_inputs();
      cycle();
    end

    // Saturation: alternating load capture / hazard bubble
    idle_inputs();
    #2 rst_n = 0;
    #1 model_clear();
    @(negedge clk);
    rst_n = 1;
    set_id(5'd8, 5'd8, 5'd0, 32'h1, 32'h2, 10'h00B);
    repeat (2 * (int'(SAT) + 6)) cycle();
    chk("sat_cnt", bubble_cnt, SAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage MIPS core. It takes decoded fields and the two operands read from the register file, applies capture-time forwarding from EX and MEM, and detects load-use hazards. It registers the result into the EX-stage operand/control bundle, handling upstream freeze, bubble insertion, flush and downstream hold. The register file's own write-back bypass covers WB→ID, so this block forwards only from EX and MEM.

## Interface
- DW, 32, data width
- RW, 5, register index width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_pc  in  DW  PC of ID instruction
- id_rs / id_rt / id_rd  in  RW  source/dest indices
- id_rdata1 / id_rdata2  in  DW  register file read data for rs / rt
- id_imm  in  DW  sign-extended immediate
- id_ctrl  in  10  [0] reg_write, [1] mem_read, [2] mem_write, [3] mem_to_reg, [4] alu_src, [5] reg_dst, [9:6] alu_op
- ex_fwd_we / ex_fwd_reg / ex_fwd_data  in  1/RW/DW  ALU result of the instruction currently in EX (non-load)
- mem_fwd_we / mem_fwd_reg / mem_fwd_data  in  1/RW/DW  final result of the instruction in MEM (incl. load data)
- flush  in  1  branch/jump taken in EX; kill ID instruction
- ex_hold  in  1  downstream stall; freeze this register
- id_ready  out  1  ID may advance; low = PC and IF/ID must hold
- ex_valid  out  1  EX slot holds a real instruction
- ex_pc, ex_a, ex_b, ex_imm  out  DW  registered PC, operands, immediate
- ex_rs, ex_rt, ex_wreg  out  RW  registered sources; resolved destination
- ex_ctrl  out  10  registered control, same layout as id_ctrl
- bubble_cnt  out  16  saturating count of load-use bubbles

## Operation
- Destination: wreg = reg_dst ? id_rd : id_rt.
- Operand A, priority order:
  - ex_fwd_data if ex_fwd_we && ex_fwd_reg==id_rs && id_rs!=0.
  - Else mem_fwd_data if mem_fwd_we && mem_fwd_reg==id_rs && id_rs!=0.
  - Else id_rdata1.
- Operand B: same rule using id_rt and id_rdata2. Register 0 is never forwarded.
- Load-use hazard: luh = id_valid && ex_valid && ex_ctrl[1] && ex_wreg!=0 && (ex_wreg==id_rs || ex_wreg==id_rt). The rt comparison is always made, conservatively.
- id_ready = !ex_hold && !(luh && !flush). This is combinational.
- Per-edge action, highest priority first:
  1. ex_hold: all ex_* and bubble_cnt unchanged; flush is ignored.
  2. flush: load a bubble.
  3. luh: load a bubble; bubble_cnt increments, saturating at 0xFFFF.
  4. !id_valid: load a bubble.
  5. Otherwise: load ex_valid=1 and all fields from ID with forwarded operands.
- A bubble is ex_valid=0 with every ex_* field 0, so ex_ctrl=0 and no write/memory side effects occur.
- The stalled ID instruction re-presents next cycle. The load is then in MEM, so it is picked up through mem_fwd.

## Timing
- Latency 1 cycle: ID values sampled at a rising edge appear on ex_* immediately after it.
- Reset (asynchronous, any time including mid-stall):
  - ex_valid=0, all ex_* = 0, bubble_cnt=0.
  - id_ready=1 while reset is asserted and in the first cycle after release.
- Load-use costs exactly one bubble. id_ready is low for one cycle per hazard unless ex_hold extends it.
- Simultaneous flush and luh: the flush bubble is inserted, id_ready=1 and bubble_cnt does not count.
- Simultaneous ex_hold and anything else: hold wins and id_ready=0.
- Forward muxes are combinational on the same cycle as capture; no extra latency.

## Test plan
- Reset: assert rst_n=0 mid-stream with ex_valid=1 → ex_valid=0, ex_a=0, ex_ctrl=0, bubble_cnt=0 before the next clk edge.
- Pass-through: rs=3, rdata1=0x11, rt=4, rdata2=0x22, rd=5, ctrl reg_dst=1, reg_write=1 → next cycle ex_a=0x11, ex_b=0x22, ex_wreg=5, ex_valid=1.
- Forward priority:
  - rs=3, ex_fwd(3, 0xAAAA), mem_fwd(3, 0xBBBB) → ex_a=0xAAAA.
  - Drop ex_fwd → ex_a=0xBBBB.
  - rs=0 with both forwards targeting 0 → ex_a=id_rdata1.
- Load-use: EX holds lw→$8; ID has rs=8 → id_ready=0 for one cycle, then ex_valid=0 and bubble_cnt=1. Next cycle, with mem_fwd(8, 0x1234), the instruction is captured with ex_a=0x1234.
- Hold vs flush: ex_hold=1 and flush=1 for 3 cycles → ex_* unchanged and id_ready=0. Release hold with flush=1 → bubble, ex_valid=0.
- Saturation: force 65536 load-use hazards → bubble_cnt stops at 0xFFFF.
